// File: rtl/sfx_scheduler.sv
// Purpose: shares one square-wave tone generator between four sound-effect requesters
//          (KO > special > heavy hit > light hit). It plays a built-in note sequence for
//          the winning effect and drives the pitch code and the staccato gate.
// Latency: a request sampled on an edge drives tone_sel/tone_en/busy from the next cycle.
// Backpressure: none. Requests are never refused. Lower-priority requests made while busy
//               are latched into pending. Higher-priority requests preempt the current effect.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   req[3:0]   effect requests, level or pulse (bit 3 = KO ... bit 0 = light hit)
//   tone_sel   pitch code to the tone generator, 0 = silence
//   tone_en    tone gate: low for the final tick of every note lasting two or more ticks
//   busy       a sequence is playing
//   active_id  effect currently playing, 0 when idle
//   done       single-cycle pulse after a sequence completes without interruption
module sfx_scheduler #(
  parameter int TICK_DIV = 3571428
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] tone_sel,
  output logic       tone_en,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Note ROM, addressed by {effect id, note index}.
  function automatic logic [3:0] rom_pitch(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'd0:    rom_pitch = 4'd5;
      4'd1:    rom_pitch = 4'd3;
      4'd4:    rom_pitch = 4'd2;
      4'd5:    rom_pitch = 4'd1;
      4'd8:    rom_pitch = 4'd6;
      4'd9:    rom_pitch = 4'd8;
      4'd10:   rom_pitch = 4'd10;
      4'd12:   rom_pitch = 4'd9;
      4'd13:   rom_pitch = 4'd7;
      4'd14:   rom_pitch = 4'd4;
      4'd15:   rom_pitch = 4'd1;
      default: rom_pitch = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] rom_dur(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'd0:    rom_dur = 3'd2;
      4'd1:    rom_dur = 3'd1;
      4'd4:    rom_dur = 3'd2;
      4'd5:    rom_dur = 3'd3;
      4'd8:    rom_dur = 3'd1;
      4'd9:    rom_dur = 3'd1;
      4'd10:   rom_dur = 3'd2;
      4'd12:   rom_dur = 3'd3;
      4'd13:   rom_dur = 3'd3;
      4'd14:   rom_dur = 3'd3;
      4'd15:   rom_dur = 3'd3;
      default: rom_dur = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] rom_count(input logic [1:0] id);
    case (id)
      2'd0:    rom_count = 3'd2;
      2'd1:    rom_count = 3'd2;
      2'd2:    rom_count = 3'd3;
      default: rom_count = 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] hi_bit(input logic [3:0] v);
    if (v[3])      hi_bit = 2'd3;
    else if (v[2]) hi_bit = 2'd2;
    else if (v[1]) hi_bit = 2'd1;
    else           hi_bit = 2'd0;
  endfunction

  function automatic logic [3:0] id_mask(input logic [1:0] id);
    id_mask = 4'b0001 << id;
  endfunction

  logic [1:0]    state;
  logic [1:0]    cur_id;
  logic [1:0]    note_idx;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    note_tick;
  logic [3:0]    pending;
  logic          done_r;

  logic [2:0] cur_dur;
  logic       tick_end;
  logic       note_end;
  logic       last_note;
  logic [1:0] req_top;
  logic [1:0] start_top;
  logic       preempt;

  assign cur_dur   = rom_dur(cur_id, note_idx);
  assign tick_end  = (tick_cnt == TICK_LAST);
  assign note_end  = tick_end && (note_tick == cur_dur - 3'd1);
  assign last_note = ({1'b0, note_idx} == rom_count(cur_id) - 3'd1);
  assign req_top   = hi_bit(req);
  assign start_top = hi_bit(req | pending);
  assign preempt   = (req != 4'd0) && (req_top > cur_id);

  // While busy, the decision order is: preempt, then natural completion, then same-id
  // restart. A same-id request that lands on the completion edge is queued. It is not
  // treated as a restart, so the finished effect still reports done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_id    <= 2'd0;
      note_idx  <= 2'd0;
      tick_cnt  <= '0;
      note_tick <= 3'd0;
      pending   <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if ((req | pending) != 4'd0) begin
          state     <= PLAY;
          cur_id    <= start_top;
          note_idx  <= 2'd0;
          tick_cnt  <= '0;
          note_tick <= 3'd0;
          pending   <= (req | pending) & ~id_mask(start_top);
        end
      end else if (preempt) begin
        // The aborted effect is dropped. Only the other requested ids stay queued.
        state     <= PLAY;
        cur_id    <= req_top;
        note_idx  <= 2'd0;
        tick_cnt  <= '0;
        note_tick <= 3'd0;
        pending   <= (pending | req) & ~id_mask(req_top);
      end else if (note_end && last_note) begin
        state     <= IDLE;
        cur_id    <= 2'd0;
        note_idx  <= 2'd0;
        tick_cnt  <= '0;
        note_tick <= 3'd0;
        done_r    <= 1'b1;
        pending   <= pending | req;
      end else if (req[cur_id]) begin
        state     <= PLAY;
        note_idx  <= 2'd0;
        tick_cnt  <= '0;
        note_tick <= 3'd0;
        pending   <= (pending | req) & ~id_mask(cur_id);
      end else begin
        pending <= pending | req;
        if (tick_end) begin
          tick_cnt <= '0;
          if (note_end) begin
            note_idx  <= note_idx + 2'd1;
            note_tick <= 3'd0;
            state     <= PLAY;
          end else begin
            note_tick <= note_tick + 3'd1;
            // Entering the final tick of a note that lasts two or more ticks closes the gate.
            if (note_tick == cur_dur - 3'd2) state <= GAP;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from registers only, so reset silences them at once.
  assign busy      = (state != IDLE);
  assign tone_sel  = busy ? rom_pitch(cur_id, note_idx) : 4'd0;
  assign tone_en   = (state == PLAY);
  assign active_id = cur_id;
  assign done      = done_r;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Purpose: scoreboard bench for sfx_scheduler, using directed scenarios followed by random requests.
// Latency: each request cycle queues the expected outputs for the cycle after the next edge.
// Backpressure: none; the monitor pops one expectation per cycle while any is queued.
module tb_sfx_scheduler;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] tone_sel;
  logic       tone_en;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  sfx_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .tone_sel(tone_sel),
    .tone_en(tone_en),
    .busy(busy),
    .active_id(active_id),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic       bsy;
    logic [1:0] id;
    logic       dn;
  } out_t;

  typedef struct packed {
    logic [3:0] p;
    logic       e;
  } seg_t;

  // Sequence tables: pitch, duration in ticks, and note count.
  int rom_p [4][4] = '{'{5, 3, 0, 0}, '{2, 1, 0, 0}, '{6, 8, 10, 0}, '{9, 7, 4, 1}};
  int rom_d [4][4] = '{'{2, 1, 0, 0}, '{2, 3, 0, 0}, '{1, 1, 2, 0}, '{3, 3, 3, 3}};
  int rom_n [4]    = '{2, 2, 3, 4};

  out_t       exp_q[$];
  seg_t       tl[$];      // remaining per-cycle outputs of the effect now playing
  bit         m_play = 0;
  int         m_id = 0;
  logic [3:0] m_pend = 4'd0;
  bit         m_done = 0;

  int checks = 0;
  int passed = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
  endtask

  function automatic int top(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // Expands an effect into its cycle-by-cycle output timeline.
  task automatic m_start(input int id);
    seg_t s;
    tl.delete();
    for (int n = 0; n < rom_n[id]; n++) begin
      for (int k = 0; k < rom_d[id][n] * TD; k++) begin
        s.p = 4'(rom_p[id][n]);
        s.e = (rom_d[id][n] == 1) || (k < (rom_d[id][n] - 1) * TD);
        tl.push_back(s);
      end
    end
    m_play = 1;
    m_id = id;
    m_pend[id] = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] r);
    seg_t s;
    out_t e;
    m_done = 0;
    if (m_play) begin
      s = tl.pop_front();
      m_pend = m_pend | r;
      if (r != 4'd0 && top(r) > m_id) m_start(top(r));
      else if (tl.size() == 0) begin
        m_play = 0;
        m_done = 1;
      end else if (r[m_id]) m_start(m_id);
    end else begin
      m_pend = m_pend | r;
      if (m_pend != 4'd0) m_start(top(m_pend));
    end
    e = '0;
    if (m_play) begin
      e.sel = tl[0].p;
      e.en  = tl[0].e;
      e.bsy = 1'b1;
      e.id  = 2'(m_id);
    end else begin
      e.dn = m_done;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    req = r;
    m_step(r);
  endtask

  task automatic m_reset();
    tl.delete();
    m_play = 0;
    m_id = 0;
    m_pend = 4'd0;
    m_done = 0;
  endtask

  // Monitor: compares one queued expectation per cycle, shortly after the edge.
  initial begin
    out_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {tone_sel, tone_en, busy, active_id, done};
        chk("cycle_out", 32'(g), 32'(e));
        if (done) done_seen++;
      end
    end
  end

  initial begin
    int d0;
    logic [3:0] r;
    #1 reset = 1'b1;
    #2 chk("reset_outputs", {23'd0, tone_sel, tone_en, busy, active_id, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (3) cyc(4'd0);

    // Basic light-hit sequence
    d0 = done_seen;
    cyc(4'b0001);
    repeat (16) cyc(4'd0);
    @(posedge clk); #3;
    chk("basic_done_count", 32'(done_seen - d0), 32'd1);

    // KO preempts light hit in its GAP tick
    d0 = done_seen;
    cyc(4'b0001);
    repeat (5) cyc(4'd0);
    cyc(4'b1000);
    repeat (55) cyc(4'd0);
    @(posedge clk); #3;
    chk("preempt_done_count", 32'(done_seen - d0), 32'd1);

    // Heavy hit queued behind special
    d0 = done_seen;
    cyc(4'b0100);
    cyc(4'd0);
    cyc(4'b0010);
    repeat (50) cyc(4'd0);
    @(posedge clk); #3;
    chk("queue_done_count", 32'(done_seen - d0), 32'd2);

    // Same-id retrigger
    d0 = done_seen;
    cyc(4'b0010);
    repeat (4) cyc(4'd0);
    cyc(4'b0010);
    repeat (40) cyc(4'd0);
    @(posedge clk); #3;
    chk("retrigger_done_count", 32'(done_seen - d0), 32'd1);

    // Three simultaneous requests play in priority order
    d0 = done_seen;
    cyc(4'b0111);
    repeat (70) cyc(4'd0);
    @(posedge clk); #3;
    chk("simul_done_count", 32'(done_seen - d0), 32'd3);

    // Reset in the middle of a KO sequence, with a queued request
    cyc(4'b1000);
    cyc(4'b0001);
    repeat (9) cyc(4'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1 chk("midseq_reset_outputs", {23'd0, tone_sel, tone_en, busy, active_id, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    exp_q.delete();
    repeat (10) cyc(4'd0);

    // Random requests
    repeat (3000) begin
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cyc(r);
    end
    repeat (60) cyc(4'd0);
    @(posedge clk); #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler that shares the single square-wave tone generator between four game-event requesters: light hit, heavy hit, special move and KO. It arbitrates the requests by fixed priority and steps through a short built-in note sequence for the winning effect. For each note it drives a pitch code and a staccato gate, which sets note length and articulation. It sits between the game-logic event pulses and the audio tone generator.

## Interface
- TICK_DIV, 3571428: clk cycles per rhythm tick (28 Hz at 100 MHz); must be ≥ 2.
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- req  in  4  effect requests, level or pulse; bit 3 = KO (highest), 2 = special, 1 = heavy hit, 0 = light hit (lowest).
- tone_sel  out  4  pitch code to tone generator; 0 = silence.
- tone_en  out  1  tone gate (staccato articulation).
- busy  out  1  a sequence is playing.
- active_id  out  2  index of the effect currently playing; 0 when idle.
- done  out  1  one-cycle pulse when a sequence completes naturally.

## Operation
- Note ROM: 4-bit pitch and 3-bit duration in ticks, up to 4 notes per effect.
  - id0: (5,2),(3,1)
  - id1: (2,2),(1,3)
  - id2: (6,1),(8,1),(10,2)
  - id3: (9,3),(7,3),(4,3),(1,3)
- Note counts are 2, 2, 3 and 4.
- pending[3:0]:
  - Set by any req bit.
  - Cleared for an id when that id starts.
  - Cleared entirely by reset.
- States: IDLE, PLAY, GAP.
- IDLE, start condition: (req | pending) ≠ 0. On that edge:
  - Select the highest set bit.
  - Load note 0 and clear the tick counter and the note tick count.
  - Go to PLAY.
- PLAY:
  - tone_sel = pitch of the current note; tone_en = 1.
  - At the end of tick (dur−1) of a note with dur ≥ 2, go to GAP.
  - A dur = 1 note has no GAP.
- GAP:
  - tone_sel keeps the pitch; tone_en = 0 for exactly one tick.
- End of a note's last tick:
  - If more notes remain, load the next note and go to PLAY.
  - Otherwise go to IDLE, pulse done = 1 and set tone_sel = 0.
- Preemption: a req with a higher index than active_id, in PLAY or GAP, aborts the current effect.
  - The new effect starts on the next edge, from note 0, with the tick counter cleared.
  - The aborted effect gives no done pulse and is dropped, not re-queued.
- Same-id retrigger: restarts the current effect from note 0 on the next edge.
- Lower-id req while busy: latched in pending and played after completion, highest pending first.
- Preemption and pending both take the highest set bit.

## Timing
- Reset values:
  - tone_sel = 0, tone_en = 0, busy = 0, active_id = 0, done = 0.
  - State IDLE, pending = 0, tick counter = 0.
- Reset mid-sequence silences the outputs immediately, asynchronously.
- Start latency: req high in cycle c → tone_sel/tone_en/busy valid from cycle c+1.
- Tick counter width is $clog2(TICK_DIV).
  - Counts 0..TICK_DIV−1, then wraps.
  - The tick-end strobe fires when the count equals TICK_DIV−1.
- A note with duration d spans exactly d×TICK_DIV cycles.
  - For d ≥ 2, tone_en is low for the last TICK_DIV cycles of the note.
- done is high for the single cycle after the final note's last cycle, with busy = 0 in that cycle.
- A pending effect starts one cycle after done, so there is one idle cycle between sequences.
- A req arriving on the same edge as completion is latched into pending. It starts on the next edge, or immediately if it preempts during PLAY or GAP.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset check: assert reset mid-sequence → all outputs 0 in the same cycle; after release the block stays IDLE with no req.
- Basic sequence: req = 0001 pulse at cycle 0 → cycles 1–4 tone_sel = 5, en = 1; 5–8 tone_sel = 5, en = 0; 9–12 tone_sel = 3, en = 1; cycle 13 done = 1, tone_sel = 0, busy = 0.
- Preemption: start id0, pulse req = 1000 at cycle 6 → cycle 7 tone_sel = 9, active_id = 3, en = 1 for 8 cycles then 0 for 4; no done until the KO sequence ends (48 cycles after start).
- Queuing: start id2, pulse req = 0010 at cycle 2 → id2 plays fully with no GAP on its dur-1 notes; done, then one idle cycle, then id1 starts (tone_sel = 2).
- Retrigger: pulse id1 at cycle 0 and again at cycle 5 → cycle 6 tone_sel = 2, en = 1, note timing restarted; exactly one done pulse.
- Simultaneous requests: req = 0111 at cycle 0 → id2 plays, then id1, then id0, each separated by a done pulse plus one idle cycle.
